// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides and an
// architectural carry register that chains add-with-carry across beats.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [1:0]       out_flags,
  output logic             carry_q
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_NAND = 3'b001,
    OP_EQ   = 3'b010,
    OP_ADDM = 3'b011,
    OP_ADC  = 3'b100,
    OP_SUB  = 3'b101,
    OP_SHL  = 3'b110,
    OP_SHR  = 3'b111
  } op_e;

  logic             s1_valid;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic s2_adv;
  logic s1_adv;
  logic accept;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = in_valid && in_ready;

  logic [SHW-1:0]   amt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_z;

  assign amt     = s1_b[SHW-1:0];
  assign sum     = {1'b0, s1_a} + {1'b0, s1_b}
                 + ((s1_op == OP_ADC) ? (WIDTH+1)'(carry_q) : '0);
  assign diff    = {1'b0, s1_a} - {1'b0, s1_b};
  // The extra bit on each shift catches the last bit shifted out; a zero
  // amount leaves it clear, so carry is 0 without a special case.
  assign shl_ext = {1'b0, s1_a} << amt;
  assign shr_ext = {s1_a, 1'b0} >> amt;

  // NOTE: every output of this always_comb gets a default first, so no path
  // through the case can leave a value unassigned and infer a latch.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    unique case (s1_op)
      OP_ADD, OP_ADC: {res_c, res} = sum;
      OP_ADDM:        res = sum[WIDTH-1:0];
      OP_NAND:        res = ~(s1_a & s1_b);
      OP_EQ:          res = diff[WIDTH-1:0];
      OP_SUB:         {res_c, res} = diff;
      OP_SHL:         {res_c, res} = shl_ext;
      OP_SHR: begin
        res   = shr_ext[WIDTH:1];
        res_c = shr_ext[0];
      end
      default: ;
    endcase
    res_z = (s1_op == OP_EQ) ? (s1_a == s1_b) : (res == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= 2'b00;
      carry_q    <= 1'b0;
    end else begin
      if (accept)      s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;

      if (s1_adv) begin
        out_valid  <= 1'b1;
        out_result <= res;
        out_flags  <= {res_c, res_z};
        carry_q    <= res_c;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // NOTE: the S1 payload is qualified by s1_valid, so it carries no reset and
  // can map onto plain enable flops.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op <= op_e'(in_op);
      s1_a  <= in_a;
      s1_b  <= in_b;
    end
  end

endmodule
